alu1_feeder: RTL and testbench



---
 rtl/alu1_feeder_pkg.sv | 33 +++
 rtl/alu1_feeder_if.sv | 48 ++++
 rtl/alu1_req_fifo.sv | 60 ++++++
 rtl/alu1_feeder.sv | 157 +++++++++++++++
 tb/tb_alu1_feeder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu1_feeder_pkg.sv
// alu1_feeder_pkg -- shared types for the ALU1 issue stage.
//   Alu1Op / ALU1_CMD_WIDTH : ALU1 command encoding.
//   alu1_req_t              : one queued request {cmd, a, b, tag} at default widths.
//   alu1_feeder_state_e     : issue FSM states.
package alu1_feeder_pkg;

  localparam int ALU1_CMD_WIDTH = 4;
  localparam int ALU1_WIDTH     = 64;
  localparam int ALU1_TAG_W     = 4;

  typedef enum logic [ALU1_CMD_WIDTH-1:0] {
    ALU1_ADD = 4'd0,
    ALU1_SUB = 4'd1,
    ALU1_AND = 4'd2,
    ALU1_OR  = 4'd3,
    ALU1_XOR = 4'd4
  } Alu1Op;

  // cmd is kept as raw bits so that illegal encodings reach ALU1 unchanged.
  typedef struct packed {
    logic [ALU1_CMD_WIDTH-1:0] cmd;
    logic [ALU1_WIDTH-1:0]     a;
    logic [ALU1_WIDTH-1:0]     b;
    logic [ALU1_TAG_W-1:0]     tag;
  } alu1_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } alu1_feeder_state_e;

endpackage

// File: rtl/alu1_feeder_if.sv
// alu1_feeder_if -- request, ALU1 and response signals of the issue stage.
//   slave  : the feeder's view (takes requests, drives ALU1, offers results).
//   master : the environment's view (producer, ALU1 and result consumer).
interface alu1_feeder_if
  import alu1_feeder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  // Request port
  logic                      in_valid;
  logic                      in_ready;
  logic [ALU1_CMD_WIDTH-1:0] in_cmd;
  logic [WIDTH-1:0]          in_a;
  logic [WIDTH-1:0]          in_b;
  logic [TAG_W-1:0]          in_tag;
  // ALU1 side
  logic [ALU1_CMD_WIDTH-1:0] alu_cmd;
  logic [WIDTH-1:0]          alu_in1;
  logic [WIDTH-1:0]          alu_in2;
  logic [WIDTH-1:0]          alu_out;
  logic                      alu_co;
  // Response port
  logic                      res_valid;
  logic                      res_ready;
  logic [WIDTH-1:0]          res_data;
  logic                      res_co;
  logic [TAG_W-1:0]          res_tag;

  modport slave (
    input  in_valid, in_cmd, in_a, in_b, in_tag,
    output in_ready,
    output alu_cmd, alu_in1, alu_in2,
    input  alu_out, alu_co,
    output res_valid, res_data, res_co, res_tag,
    input  res_ready
  );

  modport master (
    output in_valid, in_cmd, in_a, in_b, in_tag,
    input  in_ready,
    input  alu_cmd, alu_in1, alu_in2,
    output alu_out, alu_co,
    input  res_valid, res_data, res_co, res_tag,
    output res_ready
  );

endinterface

// File: rtl/alu1_req_fifo.sv
// alu1_req_fifo -- synchronous FIFO of request entries.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push_i   : write data_i (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   data_o   : head entry, valid while !empty_o
//   full_o   : count == DEPTH
//   empty_o  : count == 0
module alu1_req_fifo
  import alu1_feeder_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type elem_t = alu1_req_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  logic  pop_i,
  input  elem_t data_i,
  output elem_t data_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  elem_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; an entry is only read after it
  // has been written, so clearing it would buy nothing but reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu1_feeder.sv
// alu1_feeder -- issue stage in front of ALU1.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request port (in_*), registered ALU1 inputs (alu_cmd/in1/in2),
//              ALU1 result (alu_out/alu_co), response port (res_*)
// Requests are queued, issued to ALU1 one at a time, and the result is
// captured ALU_LAT cycles after issue and held until the consumer takes it.
module alu1_feeder
  import alu1_feeder_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 0
) (
  input logic          clk,
  input logic          rst,
  alu1_feeder_if.slave bus
);
  localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  // Same fields as alu1_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ALU1_CMD_WIDTH-1:0] cmd;
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic [TAG_W-1:0]          tag;
  } req_t;

  req_t fifo_wdata, fifo_head;
  logic fifo_full, fifo_empty, push, pop;

  alu1_feeder_state_e        state_q, state_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [ALU1_CMD_WIDTH-1:0] alu_cmd_q, alu_cmd_d;
  logic [WIDTH-1:0]          alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0]          alu_in2_q, alu_in2_d;
  logic [TAG_W-1:0]          tag_q, tag_d;
  logic                      res_valid_q, res_valid_d;
  logic [WIDTH-1:0]          res_data_q, res_data_d;
  logic                      res_co_q, res_co_d;
  logic [TAG_W-1:0]          res_tag_q, res_tag_d;

  // in_ready comes from the registered FIFO count only, so a pop in the
  // same cycle never lets a full FIFO accept.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign fifo_wdata   = '{cmd: bus.in_cmd, a: bus.in_a, b: bus.in_b, tag: bus.in_tag};

  alu1_req_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_wdata),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so
    // no path through the case below can leave one unassigned (no latches).
    state_d     = state_q;
    lat_d       = lat_q;
    alu_cmd_d   = alu_cmd_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    tag_d       = tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_co_d    = res_co_q;
    res_tag_d   = res_tag_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.alu_out;
          res_co_d    = bus.alu_co;
          res_tag_d   = tag_q;
          state_d     = ST_HOLD;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          // Issue the next op in the same cycle the result is taken.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ALU1 inputs change only when an op is popped.
    if (pop) begin
      alu_cmd_d = fifo_head.cmd;
      alu_in1_d = fifo_head.a;
      alu_in2_d = fifo_head.b;
      tag_d     = fifo_head.tag;
      lat_d     = LAT_W'(ALU_LAT);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      alu_cmd_q   <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_co_q    <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_co_q    <= res_co_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_co    = res_co_q;
  assign bus.res_tag   = res_tag_q;

endmodule

// File: tb/tb_alu1_feeder.sv
// tb_alu1_feeder -- self-checking bench for alu1_feeder.
// u_dut  : ALU_LAT = 0, driven by a combinational ALU1 stand-in.
// u_dut2 : ALU_LAT = 2, driven by a two-stage pipelined ALU1 stand-in.
// Expected results for u_dut come from a queue of accepted requests, each
// evaluated with plain arithmetic, and are compared when the result is taken.
module tb_alu1_feeder;
  import alu1_feeder_pkg::*;

  logic clk;
  logic rst;

  alu1_feeder_if #(.WIDTH(64), .TAG_W(4)) bus  ();
  alu1_feeder_if #(.WIDTH(64), .TAG_W(4)) bus2 ();

  alu1_feeder #(.WIDTH(64), .DEPTH(4), .TAG_W(4), .ALU_LAT(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu1_feeder #(.WIDTH(64), .DEPTH(4), .TAG_W(4), .ALU_LAT(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of ALU1: {carry, result}. Unknown commands return operand a.
  function automatic logic [64:0] alu1_model(logic [3:0] cmd, logic [63:0] a, logic [63:0] b);
    case (cmd)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} + {1'b0, ~b} + 65'd1;
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {bus.alu_co, bus.alu_out} = alu1_model(bus.alu_cmd, bus.alu_in1, bus.alu_in2);

  logic [64:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= alu1_model(bus2.alu_cmd, bus2.alu_in1, bus2.alu_in2);
    pipe2 <= pipe1;
  end
  assign {bus2.alu_co, bus2.alu_out} = pipe2;

  typedef struct {
    logic [63:0] data;
    logic        co;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_acc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  // One clock cycle on u_dut with scoreboard bookkeeping for both handshakes.
  task automatic step();
    logic        acc, take;
    logic [64:0] r;
    exp_t        e;
    acc  = bus.in_valid && bus.in_ready && !rst;
    take = bus.res_valid && bus.res_ready && !rst;
    if (take) begin
      check("result_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_data", bus.res_data, e.data);
        check("res_co", bus.res_co, e.co);
        check("res_tag", bus.res_tag, e.tag);
      end
    end
    if (acc) begin
      r = alu1_model(bus.in_cmd, bus.in_a, bus.in_b);
      exp_q.push_back('{data: r[63:0], co: r[64], tag: bus.in_tag});
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res_valid(input int budget);
    int n;
    n = 0;
    while (!bus.res_valid && n < budget) begin
      step();
      n++;
    end
    check("res_valid_timeout", bus.res_valid, 1'b1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [63:0] b_a, b_b;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.res_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_cmd = '0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_tag = '0;
    bus2.res_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_alu_cmd", bus.alu_cmd, 0);
    check("rst_alu_in1", bus.alu_in1, 0);
    check("rst_alu_in2", bus.alu_in2, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_co", bus.res_co, 1'b0);
    check("rst_res_tag", bus.res_tag, 0);
    check("rst2_in_ready", bus2.in_ready, 1'b1);
    check("rst2_res_valid", bus2.res_valid, 1'b0);

    // Single add 5 + 7, tag 3
    bus.res_ready = 1'b1;
    drive(4'd0, 64'h5, 64'h7, 4'd3);
    step();
    bus.in_valid = 1'b0;
    check("single_res_valid_e0", bus.res_valid, 1'b0);
    step();
    check("single_alu_in1", bus.alu_in1, 64'h5);
    check("single_alu_in2", bus.alu_in2, 64'h7);
    check("single_alu_cmd", bus.alu_cmd, 0);
    check("single_res_valid_e1", bus.res_valid, 1'b0);
    step();
    check("single_res_valid_e2", bus.res_valid, 1'b1);
    check("single_res_data", bus.res_data, 64'd12);
    check("single_res_co", bus.res_co, 1'b0);
    check("single_res_tag", bus.res_tag, 4'd3);
    step();
    check("single_res_valid_taken", bus.res_valid, 1'b0);

    // Carry out of an add
    drive(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd5);
    step();
    bus.in_valid = 1'b0;
    wait_res_valid(20);
    check("carry_res_data", bus.res_data, 64'h0);
    check("carry_res_co", bus.res_co, 1'b1);
    check("carry_res_tag", bus.res_tag, 4'd5);
    step();
    check("carry_drained", exp_q.size(), 0);

    // Full: six back-to-back requests with the consumer stalled
    bus.res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(4'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom}, 4'(i));
      step();
    end
    bus.in_valid = 1'b0;
    check("full_accepted", n_acc, 5);
    check("full_in_ready_low", bus.in_ready, 1'b0);
    check("full_res_valid", bus.res_valid, 1'b1);
    check("full_head_tag", bus.res_tag, 0);
    step();
    check("full_in_ready_still_low", bus.in_ready, 1'b0);
    bus.res_ready = 1'b1;
    step();
    check("full_in_ready_after_pop", bus.in_ready, 1'b1);
    drain(100);

    // Back-pressure: result held stable for five stalled cycles
    bus.res_ready = 1'b0;
    drive(4'd1, 64'd100, 64'd250, 4'd6);
    step();
    drive(4'd4, 64'hF0F0, 64'h0FF0, 4'd7);
    step();
    bus.in_valid = 1'b0;
    wait_res_valid(20);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_res_valid", bus.res_valid, 1'b1);
      check("bp_res_data", bus.res_data, exp_q[0].data);
      check("bp_res_tag", bus.res_tag, exp_q[0].tag);
    end
    bus.res_ready = 1'b1;
    drain(50);
    step();
    check("bp_res_valid_after", bus.res_valid, 1'b0);

    // Random traffic, including illegal command encodings
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0)
        drive(4'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(0, 15)));
      else
        bus.in_valid = 1'b0;
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    drain(200);

    // Reset while in WAIT with two ops queued
    bus.res_ready = 1'b0;
    drive(4'd0, 64'd1, 64'd2, 4'd10);
    step();
    b_a = 64'h1111;
    b_b = 64'h2222;
    drive(4'd1, b_a, b_b, 4'd11);
    step();
    drive(4'd2, 64'h3333, 64'h4444, 4'd12);
    step();
    drive(4'd3, 64'h5555, 64'h6666, 4'd13);
    step();
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    step();
    check("mid_issued_in1", bus.alu_in1, b_a);
    check("mid_issued_in2", bus.alu_in2, b_b);
    check("mid_res_valid_wait", bus.res_valid, 1'b0);
    rst = 1'b1;
    step();
    check("mid_rst_res_valid", bus.res_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_alu_cmd", bus.alu_cmd, 0);
    check("mid_rst_alu_in1", bus.alu_in1, 0);
    check("mid_rst_alu_in2", bus.alu_in2, 0);
    check("mid_rst_res_data", bus.res_data, 0);
    check("mid_rst_res_co", bus.res_co, 1'b0);
    check("mid_rst_res_tag", bus.res_tag, 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (10) step();
    check("mid_no_stale_result", bus.res_valid, 1'b0);

    // ALU_LAT = 2 instance: 10 - 3
    bus2.in_valid = 1'b1;
    bus2.in_cmd   = 4'd1;
    bus2.in_a     = 64'd10;
    bus2.in_b     = 64'd3;
    bus2.in_tag   = 4'd9;
    check("lat2_in_ready", bus2.in_ready, 1'b1);
    step();
    bus2.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("lat2_res_valid_early", bus2.res_valid, 1'b0);
    end
    step();
    check("lat2_res_valid", bus2.res_valid, 1'b1);
    check("lat2_res_data", bus2.res_data, 64'd7);
    check("lat2_res_co", bus2.res_co, 1'b1);
    check("lat2_res_tag", bus2.res_tag, 4'd9);
    step();
    check("lat2_res_valid_taken", bus2.res_valid, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
